receiver: RTL and testbench
===========================

RECEIVER -- requirements
Module: receiver

Interface
REQ-001 Parameter DATA_WIDTH, default 8: number of payload bits per frame.
REQ-002 Parameter PARITY_EN, default 1: 1 means an even-parity bit follows the payload; 0 means no parity bit.
REQ-003 Port rx_sclk_i, input, 1 bit: the single serial clock; all logic is on its rising edge.
REQ-004 Port rx_srst_i, input, 1 bit: reset, asynchronous, active-high.
REQ-005 Port rx_sdata_i, input, 1 bit: serial line; idle level 1.
REQ-006 Port rx_pready_i, input, 1 bit: the consumer accepts rx_pdata_o.
REQ-007 Port rx_pdata_o, output, DATA_WIDTH bits: received word.
REQ-008 Port rx_pdata_valid_o, output, 1 bit: rx_pdata_o holds an unconsumed word.
REQ-009 Port rx_parity_err_o, output, 1 bit: one-cycle pulse when a frame is dropped for bad parity.
REQ-010 Port rx_frame_err_o, output, 1 bit: one-cycle pulse when a frame is dropped for a bad stop bit.
REQ-011 Port rx_overrun_o, output, 1 bit: one-cycle pulse when a good frame is dropped because the output slot is full.

Function
REQ-012 Frame format: one bit per rx_sclk_i cycle, in this order:
- start bit (0);
- DATA_WIDTH payload bits, LSB first;
- parity bit, only when PARITY_EN=1; the payload plus parity bit SHALL contain an even number of ones;
- stop bit (1).
REQ-013 The FSM states SHALL be IDLE, DATA, PARITY and STOP.
REQ-014 IDLE SHALL go to DATA on the cycle after rx_sdata_i is sampled 0; otherwise it SHALL stay in IDLE.
REQ-015 DATA SHALL shift in exactly DATA_WIDTH bits, using a bit counter from 0 to DATA_WIDTH-1, then go to PARITY (PARITY_EN=1) or STOP (PARITY_EN=0).
REQ-016 PARITY SHALL sample one bit, record any mismatch, and go to STOP.
REQ-017 STOP SHALL sample one bit and return to IDLE, so a new start bit is accepted on the very next cycle.
REQ-018 A frame is good when its stop bit is 1 and parity is correct (or PARITY_EN=0).
- A good frame SHALL be loaded into the output slot.
- rx_pdata_valid_o SHALL rise on the cycle after the stop bit is sampled (latency 1).
REQ-019 Stop bit 0 SHALL discard the frame and pulse rx_frame_err_o for one cycle.
- This takes precedence over a parity error.
REQ-020 A parity mismatch with a valid stop bit SHALL discard the frame and pulse rx_parity_err_o for one cycle.
REQ-021 Handshake: the slot holds one entry.
- While rx_pdata_valid_o=1, rx_pdata_o SHALL stay stable until a cycle with rx_pready_i=1.
- rx_pdata_valid_o SHALL clear after that cycle unless it is refilled in the same cycle.
REQ-022 A good frame completing while rx_pdata_valid_o=1 and rx_pready_i=0:
- the frame SHALL be dropped;
- the old word SHALL be kept;
- rx_overrun_o SHALL pulse for one cycle.
REQ-023 A good frame completing in the same cycle that the old word is consumed SHALL be loaded, with no overrun.
REQ-024 rx_pready_i SHALL have no effect while rx_pdata_valid_o=0.
REQ-025 The error pulses SHALL be mutually exclusive and SHALL be registered outputs.

Reset
REQ-026 rx_srst_i=1 SHALL immediately force:
- FSM to IDLE;
- bit counter and shift register to 0;
- rx_pdata_o to 0;
- rx_pdata_valid_o, rx_parity_err_o, rx_frame_err_o and rx_overrun_o to 0.
REQ-027 Reset in the middle of a frame SHALL abandon it, with no error pulse.
REQ-028 After reset releases, reception SHALL start from the next 0 sampled in IDLE.

Structure
REQ-029 A shared package SHALL hold the FSM state encoding, the default DATA_WIDTH, and the idle, start and stop bit-level constants.
- The existing transmitter SHALL use this same package.
REQ-030 One sub-module, rx_shift_reg, SHALL implement the serial-in shift register and running parity.
- rx_shift_reg SHALL have clear and enable inputs.
- The FSM, bit counter and output slot SHALL stay in receiver.

Verification
REQ-031 0xA5 with rx_pready_i=1 and line 0,1,0,1,0,0,1,0,1,0,1 -> rx_pdata_valid_o=1 and rx_pdata_o=0xA5 for 1 cycle, one cycle after the stop bit.
REQ-032 0xA5 sent with parity bit 1 -> rx_parity_err_o pulses once; rx_pdata_valid_o stays 0.
REQ-033 0x3C sent with stop bit 0 -> rx_frame_err_o pulses once; no valid; a following good frame 0x3C is received correctly.
REQ-034 rx_pready_i=0, then 0x11 and 0x22 sent back-to-back -> rx_pdata_o stays 0x11 and rx_overrun_o pulses once; raising rx_pready_i then drains 0x11 and valid drops.
REQ-035 rx_srst_i asserted after 4 payload bits of 0xFF -> all outputs 0 at once; a subsequent 0x5A is received correctly with no error pulse.
REQ-036 0x80 completes in the same cycle that rx_pready_i=1 consumes the held 0x7F -> 0x80 is loaded, no overrun, valid stays 1.

Source files
------------

// File: rtl/receiver_pkg.sv
// Shared serial-link definitions for the receiver and the transmitter.
//   rx_state_t     : receiver FSM state encoding (IDLE, DATA, PARITY, STOP)
//   DATA_WIDTH_DEF : default payload width in bits
//   LINE_IDLE      : level of the serial line between frames
//   START_BIT      : level of the start bit
//   STOP_BIT       : level of a valid stop bit
package receiver_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

  localparam int   DATA_WIDTH_DEF = 8;
  localparam logic LINE_IDLE      = 1'b1;
  localparam logic START_BIT      = 1'b0;
  localparam logic STOP_BIT       = 1'b1;

endpackage

// File: rtl/receiver_shift_reg.sv
// Serial-in shift register with running parity for the receiver.
// Bits arrive LSB first and enter at the MSB end, so after DATA_WIDTH
// shifts the first bit received sits in bit 0.
//   clk    : clock, rising edge
//   rst    : asynchronous active-high reset
//   clr    : synchronous clear of word and parity
//   en     : shift one bit in from din
//   din    : serial input bit
//   data   : assembled parallel word
//   parity : XOR of all bits shifted in since the last clear
module rx_shift_reg
  import receiver_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  en,
  input  logic                  din,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  parity
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data   <= '0;
      parity <= 1'b0;
    end else if (clr) begin
      data   <= '0;
      parity <= 1'b0;
    end else if (en) begin
      data   <= {din, data[DATA_WIDTH-1:1]};
      parity <= parity ^ din;
    end
  end

endmodule

// File: rtl/receiver.sv
// Synchronous serial frame receiver with a one-entry output slot.
// Frame: start(0), DATA_WIDTH payload bits LSB first, optional even parity,
// stop(1); one bit per clock. Good frames land in the slot; bad frames are
// dropped with a one-cycle error pulse.
//   rx_sclk_i        : clock, rising edge
//   rx_srst_i        : asynchronous active-high reset
//   rx_sdata_i       : serial line, idle high
//   rx_pready_i      : consumer accepts rx_pdata_o
//   rx_pdata_o       : received word
//   rx_pdata_valid_o : rx_pdata_o holds an unconsumed word
//   rx_parity_err_o  : pulse, frame dropped for bad parity
//   rx_frame_err_o   : pulse, frame dropped for bad stop bit
//   rx_overrun_o     : pulse, good frame dropped because the slot was full
module receiver
  import receiver_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int PARITY_EN  = 1
) (
  input  logic                  rx_sclk_i,
  input  logic                  rx_srst_i,
  input  logic                  rx_sdata_i,
  input  logic                  rx_pready_i,
  output logic [DATA_WIDTH-1:0] rx_pdata_o,
  output logic                  rx_pdata_valid_o,
  output logic                  rx_parity_err_o,
  output logic                  rx_frame_err_o,
  output logic                  rx_overrun_o
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  rx_state_t             state;
  rx_state_t             state_nxt;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  last_bit;
  logic                  par_bad;
  logic                  shift_en;
  logic                  shift_clr;
  logic [DATA_WIDTH-1:0] shift_data;
  logic                  shift_par;

  logic frame_done;
  logic stop_ok;
  logic good;
  logic consume;
  logic load;

  rx_shift_reg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_shift (
    .clk    (rx_sclk_i),
    .rst    (rx_srst_i),
    .clr    (shift_clr),
    .en     (shift_en),
    .din    (rx_sdata_i),
    .data   (shift_data),
    .parity (shift_par)
  );

  assign last_bit = (bit_cnt == CNT_W'(DATA_WIDTH - 1));

  // State register
  always_ff @(posedge rx_sclk_i or posedge rx_srst_i) begin
    if (rx_srst_i) state <= IDLE;
    else           state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rx_sdata_i == START_BIT) state_nxt = DATA;
      DATA:    if (last_bit) state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY:  state_nxt = STOP;
      STOP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Shift-register control; the clear in IDLE restarts the running parity
  // for every frame while the word stays intact through STOP.
  always_comb begin
    shift_en  = (state == DATA);
    shift_clr = (state == IDLE);
  end

  // Bit counter and recorded parity mismatch
  always_ff @(posedge rx_sclk_i or posedge rx_srst_i) begin
    if (rx_srst_i) begin
      bit_cnt <= '0;
      par_bad <= 1'b0;
    end else begin
      if (state == DATA) bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
      else               bit_cnt <= '0;

      // Payload parity XOR parity bit must be 0 for even parity.
      if (state == IDLE)        par_bad <= 1'b0;
      else if (state == PARITY) par_bad <= shift_par ^ rx_sdata_i;
    end
  end

  // Frame verdict, evaluated while the stop bit is on the line.
  assign frame_done = (state == STOP);
  assign stop_ok    = (rx_sdata_i == STOP_BIT);
  assign good       = frame_done && stop_ok && !par_bad;
  assign consume    = rx_pdata_valid_o && rx_pready_i;
  // The slot can take a new word when empty or being drained this cycle.
  assign load       = good && (!rx_pdata_valid_o || rx_pready_i);

  // Output slot and registered error pulses
  always_ff @(posedge rx_sclk_i or posedge rx_srst_i) begin
    if (rx_srst_i) begin
      rx_pdata_o       <= '0;
      rx_pdata_valid_o <= 1'b0;
      rx_parity_err_o  <= 1'b0;
      rx_frame_err_o   <= 1'b0;
      rx_overrun_o     <= 1'b0;
    end else begin
      if (load) begin
        rx_pdata_o       <= shift_data;
        rx_pdata_valid_o <= 1'b1;
      end else if (consume) begin
        rx_pdata_valid_o <= 1'b0;
      end
      // Stop-bit failure outranks parity failure, keeping pulses exclusive.
      rx_frame_err_o  <= frame_done && !stop_ok;
      rx_parity_err_o <= frame_done && stop_ok && par_bad;
      rx_overrun_o    <= good && rx_pdata_valid_o && !rx_pready_i;
    end
  end

endmodule

// File: tb/tb_receiver.sv
// Directed self-checking bench for the receiver (DATA_WIDTH=8, even parity).
module tb_receiver;
  import receiver_pkg::*;

  logic       clk;
  logic       rst;
  logic       sdata;
  logic       pready;
  logic [7:0] pdata;
  logic       pvalid;
  logic       perr;
  logic       ferr;
  logic       ovr;

  int errors = 0;
  int checks = 0;

  receiver #(
    .DATA_WIDTH(8),
    .PARITY_EN (1)
  ) dut (
    .rx_sclk_i        (clk),
    .rx_srst_i        (rst),
    .rx_sdata_i       (sdata),
    .rx_pready_i      (pready),
    .rx_pdata_o       (pdata),
    .rx_pdata_valid_o (pvalid),
    .rx_parity_err_o  (perr),
    .rx_frame_err_o   (ferr),
    .rx_overrun_o     (ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Apply one line bit across the next rising edge; outputs are settled #1 later.
  task automatic send_bit(input logic b);
    sdata = b;
    @(posedge clk);
    #1;
  endtask

  // Start bit, payload LSB first, parity bit (optionally corrupted).
  task automatic send_head(input logic [7:0] d, input logic flip);
    send_bit(START_BIT);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit((^d) ^ flip);
  endtask

  task automatic send_frame(input logic [7:0] d);
    send_head(d, 1'b0);
    send_bit(STOP_BIT);
  endtask

  task automatic check_errs(input string tag, input logic p, input logic f, input logic o);
    check({tag, ".perr"}, {31'd0, perr}, {31'd0, p});
    check({tag, ".ferr"}, {31'd0, ferr}, {31'd0, f});
    check({tag, ".ovr"},  {31'd0, ovr},  {31'd0, o});
  endtask

  initial begin
    rst    = 1'b1;
    sdata  = LINE_IDLE;
    pready = 1'b0;
    #1;
    check("reset.valid", {31'd0, pvalid}, 32'd0);
    check("reset.pdata", {24'd0, pdata}, 32'd0);
    check_errs("reset", 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    send_bit(LINE_IDLE);
    send_bit(LINE_IDLE);
    check("idle.valid", {31'd0, pvalid}, 32'd0);

    // Good 0xA5 with consumer ready: valid for exactly one cycle.
    pready = 1'b1;
    send_frame(8'hA5);
    check("a5.valid", {31'd0, pvalid}, 32'd1);
    check("a5.pdata", {24'd0, pdata}, 32'h0000_00A5);
    check_errs("a5", 1'b0, 1'b0, 1'b0);
    send_bit(LINE_IDLE);
    check("a5.valid_drop", {31'd0, pvalid}, 32'd0);

    // 0xA5 with wrong parity bit (1).
    send_head(8'hA5, 1'b1);
    send_bit(STOP_BIT);
    check("par.valid", {31'd0, pvalid}, 32'd0);
    check_errs("par", 1'b1, 1'b0, 1'b0);
    send_bit(LINE_IDLE);
    check_errs("par_after", 1'b0, 1'b0, 1'b0);
    check("par.valid_after", {31'd0, pvalid}, 32'd0);

    // 0x3C with bad stop bit, then a good 0x3C.
    send_head(8'h3C, 1'b0);
    send_bit(1'b0);
    check("frm.valid", {31'd0, pvalid}, 32'd0);
    check_errs("frm", 1'b0, 1'b1, 1'b0);
    send_bit(LINE_IDLE);
    check_errs("frm_after", 1'b0, 1'b0, 1'b0);
    send_frame(8'h3C);
    check("frm_good.valid", {31'd0, pvalid}, 32'd1);
    check("frm_good.pdata", {24'd0, pdata}, 32'h0000_003C);
    check_errs("frm_good", 1'b0, 1'b0, 1'b0);
    send_bit(LINE_IDLE);
    check("frm_good.drop", {31'd0, pvalid}, 32'd0);

    // Bad parity and bad stop together: frame error only.
    send_head(8'h0F, 1'b1);
    send_bit(1'b0);
    check_errs("both", 1'b0, 1'b1, 1'b0);
    send_bit(LINE_IDLE);

    // Overrun: 0x11 then 0x22 back-to-back with consumer stalled.
    pready = 1'b0;
    send_frame(8'h11);
    check("ovr.first_valid", {31'd0, pvalid}, 32'd1);
    check("ovr.first_pdata", {24'd0, pdata}, 32'h0000_0011);
    send_frame(8'h22);
    check("ovr.pdata_kept", {24'd0, pdata}, 32'h0000_0011);
    check("ovr.valid_kept", {31'd0, pvalid}, 32'd1);
    check_errs("ovr", 1'b0, 1'b0, 1'b1);
    send_bit(LINE_IDLE);
    check_errs("ovr_after", 1'b0, 1'b0, 1'b0);
    check("ovr.pdata_hold", {24'd0, pdata}, 32'h0000_0011);
    pready = 1'b1;
    send_bit(LINE_IDLE);
    check("ovr.drained", {31'd0, pvalid}, 32'd0);

    // Mid-frame reset with a word held in the slot.
    pready = 1'b0;
    send_frame(8'h99);
    check("rst.pre_valid", {31'd0, pvalid}, 32'd1);
    send_bit(START_BIT);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rst = 1'b1;
    #1;
    check("rst.valid", {31'd0, pvalid}, 32'd0);
    check("rst.pdata", {24'd0, pdata}, 32'd0);
    check_errs("rst", 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    pready = 1'b1;
    for (int i = 0; i < 6; i++) send_bit(LINE_IDLE);
    check("rst.idle_valid", {31'd0, pvalid}, 32'd0);
    check_errs("rst_idle", 1'b0, 1'b0, 1'b0);
    send_frame(8'h5A);
    check("rst.5a_valid", {31'd0, pvalid}, 32'd1);
    check("rst.5a_pdata", {24'd0, pdata}, 32'h0000_005A);
    check_errs("rst_5a", 1'b0, 1'b0, 1'b0);
    send_bit(LINE_IDLE);

    // 0x80 completes in the cycle that drains held 0x7F.
    pready = 1'b0;
    send_frame(8'h7F);
    check("refill.7f_pdata", {24'd0, pdata}, 32'h0000_007F);
    send_head(8'h80, 1'b0);
    check("refill.7f_held", {24'd0, pdata}, 32'h0000_007F);
    pready = 1'b1;
    send_bit(STOP_BIT);
    pready = 1'b0;
    check("refill.valid", {31'd0, pvalid}, 32'd1);
    check("refill.pdata", {24'd0, pdata}, 32'h0000_0080);
    check_errs("refill", 1'b0, 1'b0, 1'b0);
    send_bit(LINE_IDLE);
    check("refill.hold_valid", {31'd0, pvalid}, 32'd1);
    check("refill.hold_pdata", {24'd0, pdata}, 32'h0000_0080);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
